poly_wave_generator: RTL and testbench

- Polyphonic square-wave note generator; parametrised successor to the single-note C generator.
- NUM_VOICES independent keyed voices, each with its own half-period, summed with saturation into one signed sample stream.
- Feeds the Audio_Controller DAC FIFO at a fixed sample rate using the audio_out_allowed handshake.
- Also drives clear_audio_out_memory when all keys are released.

---
 rtl/poly_wave_generator.sv | 164 ++++++++++++++++
 tb/tb_poly_wave_generator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/poly_wave_generator.sv
// Polyphonic square-wave generator: keyed voices summed with saturation into one sample
// stream, paced by a sample divider and handed to the DAC FIFO via audio_out_allowed.
module poly_wave_generator #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 20,
    parameter logic [NUM_VOICES*CNT_WIDTH-1:0] HALF_PERIODS = {
        20'd47778, 20'd50619, 20'd56818, 20'd63776,
        20'd71586, 20'd75843, 20'd85131, 20'd95555
    },
    parameter int unsigned AMPLITUDE  = 268435455,
    parameter int unsigned SAMPLE_DIV = 1042
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [NUM_VOICES-1:0]        play,
    input  logic                         audio_out_allowed,
    input  logic                         clear_overrun,
    output logic signed [DATA_WIDTH-1:0] audio_out,
    output logic                         write_audio_out,
    output logic                         clear_audio_out_memory,
    output logic [NUM_VOICES-1:0]        active,
    output logic                         overrun
);

    localparam int unsigned SUM_WIDTH = DATA_WIDTH + $clog2(NUM_VOICES);
    localparam int unsigned DIV_WIDTH = $clog2(SAMPLE_DIV);

    localparam logic signed [SUM_WIDTH-1:0] AMP = SUM_WIDTH'(AMPLITUDE);
    localparam logic signed [SUM_WIDTH-1:0] SUM_MAX =
        {{(SUM_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_WIDTH-1:0] SUM_MIN =
        {{(SUM_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(SAMPLE_DIV - 1);

    logic [NUM_VOICES-1:0] sync_q, active_q;
    logic [CNT_WIDTH-1:0]  cnt_q [NUM_VOICES];
    logic [NUM_VOICES-1:0] phase_q;

    logic signed [SUM_WIDTH-1:0]  sum;
    logic signed [DATA_WIDTH-1:0] mix_d, mix_q;
    logic signed [DATA_WIDTH-1:0] sample_d, sample_q;
    logic signed [DATA_WIDTH-1:0] audio_d, audio_q;
    logic [DIV_WIDTH-1:0]         div_d, div_q;
    logic pending_d, pending_q;
    logic overrun_d, overrun_q;
    logic write_d, write_q;
    logic clear_d, clear_q;
    logic any_q;
    logic tick, fall, issue;

    // Two-flop synchroniser for the asynchronous key inputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q   <= '0;
            active_q <= '0;
        end else begin
            sync_q   <= play;
            active_q <= sync_q;
        end
    end

    // Per-voice half-period counters; released keys park on the positive half.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                cnt_q[i] <= '0;
            end
            phase_q <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (!active_q[i]) begin
                    cnt_q[i]   <= '0;
                    phase_q[i] <= 1'b0;
                end else if (cnt_q[i] == HALF_PERIODS[i*CNT_WIDTH +: CNT_WIDTH] - 1'b1) begin
                    cnt_q[i]   <= '0;
                    phase_q[i] <= ~phase_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (active_q[i]) begin
                sum = phase_q[i] ? (sum - AMP) : (sum + AMP);
            end
        end
        if (sum > SUM_MAX) begin
            mix_d = OUT_MAX;
        end else if (sum < SUM_MIN) begin
            mix_d = OUT_MIN;
        end else begin
            mix_d = sum[DATA_WIDTH-1:0];
        end
    end

    assign tick  = (div_q == DIV_LAST);
    assign fall  = any_q & ~(|active_q);
    // A flush in progress suppresses the write so the FIFO starts empty.
    assign issue = pending_q & audio_out_allowed & ~write_q & ~fall;

    always_comb begin
        div_d     = tick ? '0 : div_q + 1'b1;
        sample_d  = sample_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        audio_d   = audio_q;
        write_d   = issue;
        clear_d   = fall;
        if (issue) begin
            audio_d   = sample_q;
            pending_d = 1'b0;
        end
        if (clear_overrun) begin
            overrun_d = 1'b0;
        end
        if (fall) begin
            pending_d = 1'b0;
        end else if (tick) begin
            sample_d  = mix_q;
            pending_d = 1'b1;
            if (pending_q && !issue) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            div_q     <= '0;
            mix_q     <= '0;
            sample_q  <= '0;
            audio_q   <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            write_q   <= 1'b0;
            clear_q   <= 1'b0;
            any_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            mix_q     <= mix_d;
            sample_q  <= sample_d;
            audio_q   <= audio_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            write_q   <= write_d;
            clear_q   <= clear_d;
            any_q     <= |active_q;
        end
    end

    assign audio_out              = audio_q;
    assign write_audio_out        = write_q;
    assign clear_audio_out_memory = clear_q;
    assign active                 = active_q;
    assign overrun                = overrun_q;

endmodule

// File: tb/tb_poly_wave_generator.sv
// Scoreboard bench for poly_wave_generator: a nominal instance and a saturating instance
// share stimulus; expected writes are queued per tick and popped by output monitors.
module tb_poly_wave_generator;

    localparam logic [39:0] HP = {20'd6, 20'd4};
    localparam int BIG = 1 << 30;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    logic clock, resetn, allowed, clear_ov;
    logic [1:0] play;
    logic signed [15:0] audio_a, audio_s;
    logic write_a, write_s, clear_a, clear_s, overrun_a, overrun_s;
    logic [1:0] active_a, active_s;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int st0, st1, en0, en1;
    bit auto_push;
    exp_t q_main[$];
    exp_t q_sat[$];
    int clr_q[$];
    exp_t e_a, e_s;
    int c_exp;

    poly_wave_generator #(
        .NUM_VOICES(2), .DATA_WIDTH(16), .CNT_WIDTH(20), .HALF_PERIODS(HP),
        .AMPLITUDE(100), .SAMPLE_DIV(8)
    ) dut (
        .clock(clock), .resetn(resetn), .play(play), .audio_out_allowed(allowed),
        .clear_overrun(clear_ov), .audio_out(audio_a), .write_audio_out(write_a),
        .clear_audio_out_memory(clear_a), .active(active_a), .overrun(overrun_a)
    );

    poly_wave_generator #(
        .NUM_VOICES(2), .DATA_WIDTH(16), .CNT_WIDTH(20), .HALF_PERIODS(HP),
        .AMPLITUDE(20000), .SAMPLE_DIV(8)
    ) dut_sat (
        .clock(clock), .resetn(resetn), .play(play), .audio_out_allowed(allowed),
        .clear_overrun(clear_ov), .audio_out(audio_s), .write_audio_out(write_s),
        .clear_audio_out_memory(clear_s), .active(active_s), .overrun(overrun_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edge count since reset release; matches the DUT's free-running divider phase.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else cyc <= cyc + 1;
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            assert (HP[i*20 +: 20] > 20'd1) else $fatal(1, "illegal half period for voice %0d", i);
        end
    end

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int voice_val(int n, int st, int en, int h, int amp);
        if (st < 0 || n < st || n >= en) return 0;
        return ((((n - st) / h) % 2) == 0) ? amp : -amp;
    endfunction

    // Mix register value in cycle t: sum of voice outputs one cycle earlier, clamped.
    function automatic int mix_at(int t, int amp);
        int s;
        s = voice_val(t - 1, st0, en0, 4, amp) + voice_val(t - 1, st1, en1, 6, amp);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic push(int at, int t);
        q_main.push_back('{cyc: at, val: mix_at(t, 100)});
        q_sat.push_back('{cyc: at, val: mix_at(t, 20000)});
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge clock);
    endtask

    // Unobstructed handshake: tick in cycle t gives a write in cycle t+2.
    always @(negedge clock) begin
        if (resetn && auto_push && (cyc % 8 == 7)) push(cyc + 2, cyc);
    end

    always @(negedge clock) begin
        if (write_a) begin
            if (q_main.size() == 0) begin
                check("unexpected_write", cyc, -1);
            end else begin
                e_a = q_main.pop_front();
                check("write_cycle", cyc, e_a.cyc);
                check("write_value", int'(audio_a), e_a.val);
            end
        end
    end

    always @(negedge clock) begin
        if (write_s) begin
            if (q_sat.size() == 0) begin
                check("sat_unexpected_write", cyc, -1);
            end else begin
                e_s = q_sat.pop_front();
                check("sat_write_cycle", cyc, e_s.cyc);
                check("sat_write_value", int'(audio_s), e_s.val);
            end
        end
    end

    always @(negedge clock) begin
        if (clear_a) begin
            if (clr_q.size() == 0) begin
                check("unexpected_clear", cyc, -1);
            end else begin
                c_exp = clr_q.pop_front();
                check("clear_cycle", cyc, c_exp);
                check("sat_clear_same_cycle", int'(clear_s), 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; play = 2'b00; allowed = 1'b1; clear_ov = 1'b0; auto_push = 1'b0;
        st0 = -1; st1 = -1; en0 = BIG; en1 = BIG;
        repeat (2) @(negedge clock);
        check("reset_audio_out", int'(audio_a), 0);
        check("reset_write", int'(write_a), 0);
        check("reset_clear", int'(clear_a), 0);
        check("reset_active", int'(active_a), 0);
        check("reset_overrun", int'(overrun_a), 0);
        resetn = 1'b1;
        auto_push = 1'b1;

        // Single voice, then both voices.
        wait_cyc(20); play = 2'b01; st0 = 22;
        wait_cyc(21); check("active_latency_1", int'(active_a), 0);
        wait_cyc(22); check("active_latency_2", int'(active_a), 1);
        check("sat_active", int'(active_s), 1);
        wait_cyc(60); play = 2'b11; st1 = 62;

        // Backpressure for 20 cycles; two ticks are held back, newest one survives.
        wait_cyc(121); allowed = 1'b0; auto_push = 1'b0;
        wait_cyc(135); check("overrun_before_2nd_tick", int'(overrun_a), 0);
        wait_cyc(136); check("overrun_after_2nd_tick", int'(overrun_a), 1);
        check("sat_overrun", int'(overrun_s), 1);
        push(142, 135);
        wait_cyc(141); allowed = 1'b1; auto_push = 1'b1;
        wait_cyc(150); check("overrun_sticky", int'(overrun_a), 1);
        clear_ov = 1'b1;
        wait_cyc(151); clear_ov = 1'b0;
        check("overrun_cleared", int'(overrun_a), 0);

        // Release with a sample pending: the flush must drop it.
        wait_cyc(161); allowed = 1'b0; auto_push = 1'b0;
        wait_cyc(168); play = 2'b00; en0 = 170; en1 = 170; clr_q.push_back(171);
        wait_cyc(172); allowed = 1'b1; auto_push = 1'b1;
        wait_cyc(177); check("no_overrun_after_flush", int'(overrun_a), 0);

        // Re-press voice1, then add voice0 in its negative half at sample time.
        wait_cyc(186); play = 2'b10; st1 = 188; en1 = BIG;
        wait_cyc(205); play = 2'b11; st0 = 207; en0 = BIG;

        // Hold back writes, then reset mid-operation with a sample pending.
        wait_cyc(233); allowed = 1'b0; auto_push = 1'b0;
        wait_cyc(249);
        check("overrun_before_reset", int'(overrun_a), 1);
        check("audio_out_held", int'(audio_a), -200);
        check("sat_audio_out_held", int'(audio_s), -32768);
        check("active_before_reset", int'(active_a), 3);
        wait_cyc(250);
        resetn = 1'b0;
        #1;
        check("async_reset_audio_out", int'(audio_a), 0);
        check("async_reset_sat_audio_out", int'(audio_s), 0);
        check("async_reset_write", int'(write_a), 0);
        check("async_reset_clear", int'(clear_a), 0);
        check("async_reset_active", int'(active_a), 0);
        check("async_reset_overrun", int'(overrun_a), 0);
        check("queue_empty_at_reset", q_main.size(), 0);
        repeat (3) @(negedge clock);
        st0 = 2; st1 = 2; en0 = BIG; en1 = BIG; allowed = 1'b1;
        resetn = 1'b1;
        auto_push = 1'b1;
        wait_cyc(44);

        check("leftover_expected_writes", q_main.size(), 0);
        check("sat_leftover_expected_writes", q_sat.size(), 0);
        check("leftover_expected_clears", clr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
